// File: rtl/aes128_encrypt_core_if.sv
// Purpose: start/done handshake bundle for the iterative AES-128 encrypt core.
// Latency: n/a (wires only).
// Backpressure: none; the requester drives start while the core is idle.
// Ports: start, plaintext, key (requester -> core); ciphertext, done (core -> requester).
interface aes128_encrypt_core_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;

  modport master (output start, plaintext, key, input ciphertext, done);
  modport slave  (input start, plaintext, key, output ciphertext, done);
endinterface

// File: rtl/aes128_encrypt_core.sv
// Purpose: iterative AES-128 encryption, one round per clock, round keys expanded on the fly.
// Latency: done/ciphertext 10 rising edges after the edge that samples start.
// Backpressure: start is only honoured in IDLE; a start seen while running is dropped.
// Ports: clk, reset (async active-low), bus (slave: start/plaintext/key in, ciphertext/done out).
module aes128_encrypt_core (
  input  logic                  clk,
  input  logic                  reset,
  aes128_encrypt_core_if.slave  bus
);

  // Forward S-box, element 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_blk;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic [127:0] r_ciphertext;
  logic         r_done;

  logic         w_load;
  logic         w_step;
  logic         w_last;
  logic         w_final_round;

  logic [7:0]   w_sb [16];
  logic [7:0]   w_sr [16];
  logic [7:0]   w_mc [16];
  logic [127:0] w_mix_blk;
  logic [127:0] w_rnd_out;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_rk_next;

  assign w_final_round = (r_round == 4'd10);

  // Round datapath. Vector byte i is state byte i; s[r][c] lives at byte 4c+r.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign w_sb[i] = sbox(r_blk[127-8*i -: 8]);
  end

  // ShiftRows rotates row r left by r: s'[r][c] = s[r][(c+r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    end
    assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
  end

  // The final round has no MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_pack
    assign w_mix_blk[127-8*i -: 8] = w_final_round ? w_sr[i] : w_mc[i];
  end

  assign w_rnd_out = w_mix_blk ^ w_rk_next;

  // Next round key from the current one: RotWord, SubWord, Rcon on the last word.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_ksub
    assign w_sub[31-8*k -: 8] = sbox(w_rot[31-8*k -: 8]);
  end
  assign w_temp    = w_sub ^ {rcon(r_round), 24'h0};
  assign w_k0      = r_rk[127:96] ^ w_temp;
  assign w_k1      = r_rk[95:64]  ^ w_k0;
  assign w_k2      = r_rk[63:32]  ^ w_k1;
  assign w_k3      = r_rk[31:0]   ^ w_k2;
  assign w_rk_next = {w_k0, w_k1, w_k2, w_k3};

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_final_round) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: control outputs.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE:  w_load = bus.start;
      S_RUN: begin
        w_step = 1'b1;
        w_last = w_final_round;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk        <= '0;
      r_rk         <= '0;
      r_round      <= '0;
      r_ciphertext <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_blk   <= bus.plaintext ^ bus.key;
        r_rk    <= bus.key;
        r_round <= 4'd1;
      end else if (w_step) begin
        r_blk   <= w_rnd_out;
        r_rk    <= w_rk_next;
        r_round <= r_round + 4'd1;
      end
      if (w_last) r_ciphertext <= w_rnd_out;
    end
  end

  assign bus.ciphertext = r_ciphertext;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Purpose: directed bench for aes128_encrypt_core using FIPS-197 vectors and a result queue.
// Latency: expects done 10 edges after the start edge.
// Backpressure: exercises busy-start, held start, back-to-back and mid-run reset.
module tb_aes128_encrypt_core;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic reset;

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns on the falling edge after the start edge.
  task automatic pulse_start(input logic [127:0] pt, input logic [127:0] k,
                             input bit expect_result, input logic [127:0] ct);
    bus.plaintext = pt;
    bus.key       = k;
    bus.start     = 1'b1;
    if (expect_result) exp_q.push_back(ct);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // k0 = edges already elapsed since the start edge at the current falling edge.
  task automatic wait_done(input string tag, input int k0);
    int k;
    logic [127:0] exp;
    k = k0;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 128'(k), 128'(10));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, " ciphertext"}, bus.ciphertext, exp);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int cnt;
    bus.start     = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    reset         = 1'b0;

    #3;
    check("reset ciphertext", bus.ciphertext, '0);
    check("reset done", 128'(bus.done), '0);
    #7 reset = 1'b1;
    @(negedge clk);
    check("idle ciphertext", bus.ciphertext, '0);
    check("idle done", 128'(bus.done), '0);

    // FIPS-197 Appendix B.
    pulse_start(PT_B, KEY_B, 1'b1, CT_B);
    wait_done("appB", 0);
    @(negedge clk);
    check("appB done clears", 128'(bus.done), '0);
    check("appB ciphertext holds", bus.ciphertext, CT_B);

    // App C.1 then all-zero, back to back on the edge after done.
    pulse_start(PT_C, KEY_C, 1'b1, CT_C);
    wait_done("appC", 0);
    pulse_start('0, '0, 1'b1, CT_Z);
    wait_done("zero", 0);

    // Start and input changes during a run must not disturb it.
    pulse_start(PT_B, KEY_B, 1'b1, CT_B);
    repeat (3) @(negedge clk);
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy", 4);
    count_dones(12, cnt);
    check("busy no second done", 128'(cnt), '0);
    pulse_start(PT_C, KEY_C, 1'b1, CT_C);
    wait_done("after busy appC", 0);

    // Start held high: a new operation on every return to idle.
    bus.plaintext = '0;
    bus.key       = '0;
    bus.start     = 1'b1;
    exp_q.push_back(CT_Z);
    exp_q.push_back(CT_Z);
    @(negedge clk);
    wait_done("held 1", 0);
    @(negedge clk);
    wait_done("held 2", 0);
    bus.start = 1'b0;

    // Reset mid-operation aborts without a done.
    pulse_start(PT_B, KEY_B, 1'b0, CT_B);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid reset ciphertext", bus.ciphertext, '0);
    check("mid reset done", 128'(bus.done), '0);
    @(negedge clk);
    reset = 1'b1;
    count_dones(15, cnt);
    check("post reset no done", 128'(cnt), '0);
    check("post reset ciphertext", bus.ciphertext, '0);
    pulse_start(PT_B, KEY_B, 1'b1, CT_B);
    wait_done("post reset appB", 0);

    check("scoreboard drained", 128'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
